// File: rtl/mult_mem_if.sv
// Memory access unit for the multicycle core: launches fetch/load/store on a req/ack memory port,
// holds IR and MDR, and stalls the controller while an access is in flight. Option: MULT_MEM_TIMEOUT_EN.
module mult_mem_if #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   PC,
    input  logic [31:0]   ALU_OUT,
    input  logic          IR_WE,
    input  logic          DATA_RD,
    input  logic          IDMEM_WE,
    input  logic [31:0]   WDATA,
    output logic          STALL,
    output logic [31:0]   IR,
    output logic [5:0]    OP,
    output logic [5:0]    FUNCT,
    output logic [31:0]   MDR,
    output logic          ERR,
    output logic          M_REQ,
    output logic          M_WE,
    output logic [AW-1:0] M_ADDR,
    output logic [31:0]   M_WDATA,
    input  logic          M_ACK,
    input  logic [31:0]   M_RDATA,
    output logic [1:0]    DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_FETCH = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } kind_t;

    state_t state;
    kind_t  kind;
    logic   start;
    logic   expired;

    assign start     = IR_WE | DATA_RD | IDMEM_WE;
    assign STALL     = ((state == S_IDLE) && start) || (state == S_ACCESS);
    assign OP        = IR[31:26];
    assign FUNCT     = IR[5:0];
    assign DBG_STATE = state;

    // Byte-lane bits and bits above the memory range never reach the memory port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:AW+2], PC[1:0], ALU_OUT[31:AW+2], ALU_OUT[1:0]};

`ifdef MULT_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // cnt counts completed ACCESS cycles; expiry is the TIMEOUT-th ACCESS cycle.
    assign expired = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            ERR <= 1'b0;
        end else if (state == S_ACCESS) begin
            cnt <= cnt + 1'b1;
            if (!M_ACK && expired) ERR <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign expired = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            kind    <= K_FETCH;
            IR      <= '0;
            MDR     <= '0;
            M_REQ   <= 1'b0;
            M_WE    <= 1'b0;
            M_ADDR  <= '0;
            M_WDATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (IR_WE) begin
                            kind   <= K_FETCH;
                            M_ADDR <= PC[AW+1:2];
                            M_WE   <= 1'b0;
                        end else if (IDMEM_WE) begin
                            kind   <= K_STORE;
                            M_ADDR <= ALU_OUT[AW+1:2];
                            M_WE   <= 1'b1;
                        end else begin
                            kind   <= K_LOAD;
                            M_ADDR <= ALU_OUT[AW+1:2];
                            M_WE   <= 1'b0;
                        end
                        M_WDATA <= WDATA;
                        M_REQ   <= 1'b1;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // An ack arriving in the expiry cycle still completes normally.
                    if (M_ACK) begin
                        if (kind == K_FETCH) IR  <= M_RDATA;
                        if (kind == K_LOAD)  MDR <= M_RDATA;
                        M_REQ <= 1'b0;
                        state <= S_DONE;
                    end else if (expired) begin
                        M_REQ <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_mem_if.sv
// Bench for mult_mem_if: randomized memory responder, queue-based reference model and monitor.
// Handshake: an access is complete in the cycle where m_req and m_ack are both high at the sample point.
module tb_mult_mem_if;

    localparam int AW = 8;
    localparam int TO = 4;
    // Expected entry: {we, addr, wdata, ir_after, mdr_after}
    localparam int W  = 1 + AW + 96;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   pc = '0, alu_out = '0, wdata = '0;
    logic          ir_we = 1'b0, data_rd = 1'b0, idmem_we = 1'b0;
    logic          stall, err, m_req, m_we;
    logic [31:0]   ir, mdr, m_wdata;
    logic [5:0]    op, funct;
    logic [AW-1:0] m_addr;
    logic          m_ack = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] mem_arr [256];
    logic [31:0] ref_ir  = '0;
    logic [31:0] ref_mdr = '0;
    logic [W-1:0] exp_q[$];

    bit resp_en     = 1'b1;
    int force_waits = -1;
    int cur_waits   = 0;
    bit in_req      = 1'b0;
    bit ack_sent    = 1'b0;
    int wait_cnt    = 0;

    mult_mem_if #(.AW(AW), .TIMEOUT(TO)) dut (
        .CLK(clk), .RST(rst), .PC(pc), .ALU_OUT(alu_out),
        .IR_WE(ir_we), .DATA_RD(data_rd), .IDMEM_WE(idmem_we), .WDATA(wdata),
        .STALL(stall), .IR(ir), .OP(op), .FUNCT(funct), .MDR(mdr), .ERR(err),
        .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
        .M_ACK(m_ack), .M_RDATA(m_rdata), .DBG_STATE(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: random wait states, stray acks with junk data while no request is open.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (m_req) begin
                    if (!in_req) begin
                        in_req    = 1'b1;
                        ack_sent  = 1'b0;
                        wait_cnt  = 0;
                        cur_waits = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
                    end
                    if (!ack_sent && wait_cnt == cur_waits) begin
                        m_ack   = 1'b1;
                        m_rdata = mem_arr[m_addr];
                        if (m_we) mem_arr[m_addr] = m_wdata;
                        ack_sent = 1'b1;
                    end else begin
                        m_ack   = 1'b0;
                        m_rdata = $urandom;
                        wait_cnt++;
                    end
                end else begin
                    in_req  = 1'b0;
                    m_ack   = 1'($urandom_range(0, 1));
                    m_rdata = $urandom;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] cur;
        bit pending;
        int stall_cnt;
        int exp_stall;
        pending   = 1'b0;
        stall_cnt = 0;
        exp_stall = 0;
        cur       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pending   = 1'b0;
                stall_cnt = 0;
            end else begin
                if (stall) stall_cnt++;
                if (m_req) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL spurious_req actual=m_req_high required=no_request addr=0x%0h", m_addr);
                    end else begin
                        e = exp_q[0];
                        check("m_we",    32'(m_we),    32'(e[96+AW]));
                        check("m_addr",  32'(m_addr),  32'(e[95+AW:96]));
                        check("m_wdata", m_wdata,      e[95:64]);
                        if (m_ack) begin
                            cur       = exp_q.pop_front();
                            pending   = 1'b1;
                            exp_stall = cur_waits + 2;
                        end
                    end
                end
                if (!stall) begin
                    if (pending) begin
                        check("ir_done",     ir,              cur[63:32]);
                        check("mdr_done",    mdr,             cur[31:0]);
                        check("op_done",     32'(op),         32'(cur[63:58]));
                        check("funct_done",  32'(funct),      32'(cur[37:32]));
                        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
                        pending = 1'b0;
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Driver: reference model update plus strobe handshake; called at a negedge.
    task automatic issue(input bit f, input bit s, input bit l, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] d, input bit hold, input int waits);
        logic [AW-1:0] addr;
        bit we;
        int n;
        force_waits = waits;
        if (f) begin
            addr   = AW'(p >> 2);
            we     = 1'b0;
            ref_ir = ref_mem[addr];
        end else if (s) begin
            addr          = AW'(a >> 2);
            we            = 1'b1;
            ref_mem[addr] = d;
        end else begin
            addr    = AW'(a >> 2);
            we      = 1'b0;
            ref_mdr = ref_mem[addr];
        end
        exp_q.push_back({we, addr, d, ref_ir, ref_mdr});
        pc = p; alu_out = a; wdata = d;
        ir_we = f; idmem_we = s; data_rd = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 100);
        check("stall_release", 32'(stall), 32'd0);
        if (hold) @(negedge clk);
        ir_we = 1'b0; idmem_we = 1'b0; data_rd = 1'b0;
        pc = $urandom; alu_out = $urandom; wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, p;
        int k;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[4] = 32'h8C22_0004; mem_arr[4] = 32'h8C22_0004;
        ref_mem[8] = 32'hDEAD_BEEF; mem_arr[8] = 32'hDEAD_BEEF;

        // reset state
        rst = 1'b1;
        idle(3);
        check("rst_ir",      ir,              32'd0);
        check("rst_mdr",     mdr,             32'd0);
        check("rst_m_req",   32'(m_req),      32'd0);
        check("rst_m_we",    32'(m_we),       32'd0);
        check("rst_m_addr",  32'(m_addr),     32'd0);
        check("rst_m_wdata", m_wdata,         32'd0);
        check("rst_err",     32'(err),        32'd0);
        check("rst_stall",   32'(stall),      32'd0);
        rst = 1'b0;
        idle(2);

        // zero-wait fetch
        issue(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0);
        check("t1_op",    32'(op),    32'h23);
        check("t1_funct", 32'(funct), 32'h04);
        idle(1);
        // load with 3 waits
        issue(0, 0, 1, 32'h0, 32'h20, 32'h0, 0, 3);
        check("t2_mdr", mdr, 32'hDEAD_BEEF);
        idle(1);
        // store with 2 waits
        issue(0, 1, 0, 32'h0, 32'h24, 32'h1234_5678, 0, 2);
        idle(1);
        check("t3_mem_written", mem_arr[9], 32'h1234_5678);
        // fetch wins over load; strobes held through DONE
        issue(1, 0, 1, 32'h50, 32'h60, 32'h0, 1, 1);
        idle(3);

        // reset in the second ACCESS cycle, late ack afterwards
        resp_en = 1'b0; m_ack = 1'b0;
        exp_q.push_back({1'b0, AW'(32'h40 >> 2), 32'h0, ref_ir, ref_mdr});
        pc = 32'h40; wdata = 32'h0; ir_we = 1'b1;
        idle(2);
        rst = 1'b1;
        exp_q.delete();
        idle(1);
        rst = 1'b0; ir_we = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        ref_ir = '0; ref_mdr = '0;
        idle(1);
        m_ack = 1'b0;
        check("t5_m_req", 32'(m_req), 32'd0);
        check("t5_ir",    ir,         32'd0);
        check("t5_mdr",   mdr,        32'd0);
        check("t5_stall", 32'(stall), 32'd0);
        resp_en = 1'b1;
        idle(2);

        // randomized traffic over a small word window so loads/fetches see earlier stores
        for (int t = 0; t < 40; t++) begin
            k = int'($urandom_range(1, 7));
            p = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            issue(k[0], k[1], k[2], p, a, $urandom, bit'($urandom_range(0, 1)), -1);
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        check("rand_err_clear", 32'(err), 32'd0);

        // no ack at all
        resp_en = 1'b0; m_ack = 1'b0;
        exp_q.push_back({1'b0, AW'(32'h30 >> 2), 32'h0, ref_ir, ref_mdr});
        alu_out = 32'h30; wdata = 32'h0; data_rd = 1'b1;
`ifdef MULT_MEM_TIMEOUT_EN
        repeat (TO) begin
            idle(1);
            check("t6_stall_access", 32'(stall), 32'd1);
        end
        idle(1);
        check("t6_stall_done", 32'(stall), 32'd0);
        check("t6_err",        32'(err),   32'd1);
        check("t6_m_req",      32'(m_req), 32'd0);
        check("t6_ir",         ir,         ref_ir);
        check("t6_mdr",        mdr,        ref_mdr);
        exp_q.delete();
        data_rd = 1'b0;
        idle(2);
        check("t6_err_sticky", 32'(err), 32'd1);
`else
        idle(20);
        check("t6_stall_held", 32'(stall), 32'd1);
        check("t6_err_zero",   32'(err),   32'd0);
        check("t6_m_req_held", 32'(m_req), 32'd1);
`endif
        rst = 1'b1;
        exp_q.delete();
        idle(1);
        rst = 1'b0; data_rd = 1'b0;
        idle(1);
        check("t6_err_after_rst",   32'(err),   32'd0);
        check("t6_stall_after_rst", 32'(stall), 32'd0);
        resp_en = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
